// File: rtl/wb_master_if.sv
// Core request/response channel and Wishbone pipelined bus of the load/store
// initiator, seen from the initiator (master) or from the core/responder side (slave).
interface wb_master_if;
    // Core request channel
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [63:0] i_req_addr;
    logic [63:0] i_req_wdata;
    logic [1:0]  i_req_size;
    logic        i_req_signed;
    // Core response channel
    logic        o_rsp_valid;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err;
    // Wishbone bus
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [63:0] o_wb_adr;
    logic [63:0] o_wb_dat;
    logic [7:0]  o_wb_sel;
    logic [63:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_stall;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_signed,
        output o_req_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        input  i_wb_dat, i_wb_ack, i_wb_stall
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_signed,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
        output i_wb_dat, i_wb_ack, i_wb_stall
    );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding Wishbone (pipelined, stall/ack) initiator for the core
// load/store path. One sized request at a time; a watchdog turns a missing
// acknowledge into an error response so unmapped addresses never hang the core.
module wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    wb_master_if.master bus
);
    // Watchdog value seen during the last cycle cyc may stay high.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        live_q, live_d;       // low only until the first edge after reset
    logic [15:0] wdog_q, wdog_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [63:0] adr_q, adr_d;
    logic [63:0] dat_q, dat_d;
    logic [7:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    logic [63:0] load_result;

    // A request is misaligned when any address bit below its size is set.
    function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] size);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = a[0];
            2'd2:    r = |a[1:0];
            default: r = |a;
        endcase
        return r;
    endfunction

    // Byte-lane enables for a right-justified access.
    function automatic logic [7:0] lane_sel(input logic [1:0] size);
        logic [7:0] r;
        case (size)
            2'd0:    r = 8'h01;
            2'd1:    r = 8'h03;
            2'd2:    r = 8'h0F;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // Store data with the bytes above the access size forced to zero.
    function automatic logic [63:0] store_data(input logic [63:0] w, input logic [1:0] size);
        logic [63:0] r;
        case (size)
            2'd0:    r = {56'd0, w[7:0]};
            2'd1:    r = {48'd0, w[15:0]};
            2'd2:    r = {32'd0, w[31:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Load data taken from the low lanes and sign- or zero-extended.
    function automatic logic [63:0] load_data(input logic [63:0] d, input logic [1:0] size,
                                              input logic sgn);
        logic [63:0] r;
        case (size)
            2'd0:    r = {{56{sgn & d[7]}},  d[7:0]};
            2'd1:    r = {{48{sgn & d[15]}}, d[15:0]};
            2'd2:    r = {{32{sgn & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Stores always answer with zero data.
    assign load_result = we_q ? 64'd0 : load_data(bus.i_wb_dat, size_q, sgn_q);

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        live_d      = 1'b1;
        wdog_d      = wdog_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 64'd0;

        case (state_q)
            ST_IDLE: begin
                if (live_q && bus.i_req_valid) begin
                    size_d = bus.i_req_size;
                    sgn_d  = bus.i_req_signed;
                    if (ALIGN_CHECK && is_misaligned(bus.i_req_addr[2:0], bus.i_req_size)) begin
                        // Rejected without touching the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = bus.i_req_we;
                        adr_d   = bus.i_req_addr;
                        dat_d   = store_data(bus.i_req_wdata, bus.i_req_size);
                        sel_d   = lane_sel(bus.i_req_size);
                        wdog_d  = 16'd0;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                wdog_d = wdog_q + 16'd1;
                if (bus.i_wb_ack) begin
                    // Ack completes the access even if it arrives while stalled.
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_result;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d     = ST_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (state_q == ST_REQ && !bus.i_wb_stall) begin
                    state_d = ST_WAIT;
                    stb_d   = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            live_q      <= 1'b0;
            wdog_q      <= 16'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 64'd0;
            dat_q       <= 64'd0;
            sel_q       <= 8'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_d;
            wdog_q      <= wdog_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.o_req_ready = live_q && (state_q == ST_IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_wb_cyc    = cyc_q;
    assign bus.o_wb_stb    = stb_q;
    assign bus.o_wb_we     = we_q;
    assign bus.o_wb_adr    = adr_q;
    assign bus.o_wb_dat    = dat_q;
    assign bus.o_wb_sel    = sel_q;
endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed vector table, reset-in-WAIT sequence and
// randomized transactions checked against a behavioural model.
module tb_wb_master;
    localparam int TMO = 8;
    localparam int NEVER = 1000;

    logic clk;
    logic rst_n;
    wb_master_if bus();

    wb_master #(.TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1'b1)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        int          stall_n;   // responder stalls the first stall_n bus cycles
        int          ack_at;    // bus cycle index (0 = first cyc cycle) of the ack
        logic [63:0] rdat;
        logic [63:0] e_rdata;
        logic        e_err;
        logic [7:0]  e_sel;
        logic [63:0] e_dat;
        int          e_cyc;     // cycles cyc is high
        int          e_stb;     // cycles stb is high
        int          e_lat;     // cycle of rsp_valid after the accepting edge
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [1:0] size, input logic sgn, input int stall_n,
                                input int ack_at, input logic [63:0] rdat, input logic [63:0] e_rdata,
                                input logic e_err, input logic [7:0] e_sel, input logic [63:0] e_dat,
                                input int e_cyc, input int e_stb, input int e_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn;
        v.stall_n = stall_n; v.ack_at = ack_at; v.rdat = rdat;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_sel = e_sel; v.e_dat = e_dat;
        v.e_cyc = e_cyc; v.e_stb = e_stb; v.e_lat = e_lat;
        return v;
    endfunction

    // Reference model: expected outcome from the request and responder behaviour.
    function automatic vec_t model(input vec_t vin);
        vec_t v = vin;
        int nbytes = 1 << v.size;
        int bits = 8 * nbytes;
        logic [63:0] mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        logic [63:0] lane;
        int bus_len;
        v.e_sel = 8'((1 << nbytes) - 1);
        v.e_dat = v.wdata & mask;
        if ((v.addr % 64'(nbytes)) != 0) begin
            v.e_err = 1'b1; v.e_rdata = 64'd0; v.e_cyc = 0; v.e_stb = 0; v.e_lat = 1;
        end else begin
            bus_len = (v.ack_at < TMO) ? v.ack_at + 1 : TMO;
            v.e_err = (v.ack_at >= TMO);
            v.e_cyc = bus_len;
            v.e_stb = (v.stall_n + 1 < bus_len) ? v.stall_n + 1 : bus_len;
            v.e_lat = bus_len + 1;
            lane = v.rdat & mask;
            if (v.sgn && lane[bits-1]) lane = lane | ~mask;
            v.e_rdata = (v.e_err || v.we) ? 64'd0 : lane;
        end
        return v;
    endfunction

    // Drive one request, act as responder, and compare everything observed.
    task automatic apply(input vec_t v, input int idx);
        int waited = 0;
        int j = 0;
        int cyc_n = 0;
        int stb_n = 0;
        int rsp_n = 0;
        int rsp_cyc = -1;
        int bad_bus = 0;
        logic [63:0] rsp_rd = '0;
        logic rsp_e = 1'b0;
        @(negedge clk);
        while (!bus.o_req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready", 64'(bus.o_req_ready), 64'd1);
        bus.i_req_valid = 1'b1; bus.i_req_we = v.we; bus.i_req_addr = v.addr;
        bus.i_req_wdata = v.wdata; bus.i_req_size = v.size; bus.i_req_signed = v.sgn;
        bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.i_req_addr = {$urandom, $urandom};
        bus.i_req_wdata = {$urandom, $urandom};
        for (int c = 1; c <= 40; c++) begin
            if (bus.o_wb_cyc) begin
                cyc_n++;
                if (bus.o_wb_stb) stb_n++;
                if (bus.o_wb_adr !== v.addr || bus.o_wb_dat !== v.e_dat ||
                    bus.o_wb_sel !== v.e_sel || bus.o_wb_we !== v.we) bad_bus++;
                bus.i_wb_stall = (j < v.stall_n);
                bus.i_wb_ack = (j == v.ack_at);
                bus.i_wb_dat = (j == v.ack_at) ? v.rdat : {$urandom, $urandom};
                j++;
            end else begin
                // Acks outside a bus cycle must be ignored.
                bus.i_wb_stall = 1'($urandom);
                bus.i_wb_ack = 1'($urandom);
                bus.i_wb_dat = {$urandom, $urandom};
            end
            if (bus.o_rsp_valid) begin
                rsp_n++;
                if (rsp_n == 1) begin
                    rsp_cyc = c; rsp_rd = bus.o_rsp_rdata; rsp_e = bus.o_rsp_err;
                end
            end
            if (rsp_n > 0 && c >= rsp_cyc + 2) break;
            @(posedge clk); #1;
        end
        bus.i_wb_ack = 1'b0;
        bus.i_wb_stall = 1'b0;
        chk("rsp_count", 64'(rsp_n), 64'd1);
        chk("rsp_latency", 64'(rsp_cyc), 64'(v.e_lat));
        chk("rsp_rdata", rsp_rd, v.e_rdata);
        chk("rsp_err", 64'(rsp_e), 64'(v.e_err));
        chk("cyc_cycles", 64'(cyc_n), 64'(v.e_cyc));
        chk("stb_cycles", 64'(stb_n), 64'(v.e_stb));
        chk("bus_fields", 64'(bad_bus), 64'd0);
        $display("txn %0d we=%0d size=%0d addr=%h stall=%0d ack_at=%0d lat=%0d err=%0d rdata=%h",
                 idx, v.we, v.size, v.addr, v.stall_n, v.ack_at, rsp_cyc, rsp_e, rsp_rd);
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "global timeout");
    end

    initial begin
        bit saw_rsp;
        vec_t rv;
        tbl[0] = mk(0, 64'h8000_0010, 64'd0, 2'd3, 0, 0, 0, 64'h1122_3344_5566_7788,
                    64'h1122_3344_5566_7788, 0, 8'hFF, 64'd0, 1, 1, 2);
        tbl[1] = mk(0, 64'h8000_0003, 64'd0, 2'd0, 1, 0, 0, 64'h5555_5555_5555_5580,
                    64'hFFFF_FFFF_FFFF_FF80, 0, 8'h01, 64'd0, 1, 1, 2);
        tbl[2] = mk(0, 64'h8000_0003, 64'd0, 2'd0, 0, 0, 0, 64'h5555_5555_5555_5580,
                    64'h0000_0000_0000_0080, 0, 8'h01, 64'd0, 1, 1, 2);
        tbl[3] = mk(1, 64'h8000_0006, 64'hDEAD_BEEF_CAFE_1234, 2'd1, 0, 3, 5, 64'hAAAA_AAAA_AAAA_AAAA,
                    64'd0, 0, 8'h03, 64'h1234, 6, 4, 7);
        tbl[4] = mk(0, 64'h8000_0002, 64'd0, 2'd2, 0, 0, 0, 64'h1234,
                    64'd0, 1, 8'h0F, 64'd0, 0, 0, 1);
        tbl[5] = mk(0, 64'h8000_0100, 64'd0, 2'd3, 0, 0, NEVER, 64'h1234,
                    64'd0, 1, 8'hFF, 64'd0, 8, 1, 9);
        tbl[6] = mk(0, 64'h8000_0004, 64'd0, 2'd2, 1, 0, 1, 64'h1234_5678_8000_0001,
                    64'hFFFF_FFFF_8000_0001, 0, 8'h0F, 64'd0, 2, 1, 3);
        tbl[7] = mk(0, 64'h8000_000A, 64'd0, 2'd1, 0, 5, 2, 64'hFFFF_FFFF_FFFF_F00D,
                    64'h0000_0000_0000_F00D, 0, 8'h03, 64'd0, 3, 3, 4);
        tbl[8] = mk(1, 64'h8000_0007, 64'h0123_4567_89AB_CDA5, 2'd0, 0, 20, NEVER, 64'd0,
                    64'd0, 1, 8'h01, 64'h0000_0000_0000_00A5, 8, 8, 9);
        tbl[9] = mk(1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 0, 7, 64'd0,
                    64'd0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 8, 1, 9);

        rst_n = 1'b0;
        bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
        bus.i_req_size = 2'd0; bus.i_req_signed = 1'b0;
        bus.i_wb_dat = '0; bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
        #2;
        chk("reset_ready", 64'(bus.o_req_ready), 64'd0);
        chk("reset_cyc", 64'(bus.o_wb_cyc), 64'd0);
        chk("reset_stb", 64'(bus.o_wb_stb), 64'd0);
        chk("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        chk("reset_sel", 64'(bus.o_wb_sel), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_ready", 64'(bus.o_req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(bus.o_req_ready), 64'd1);

        for (int i = 0; i < 10; i++) apply(tbl[i], i);

        // Reset asserted while waiting for ack.
        @(negedge clk);
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 64'h8000_0020;
        bus.i_req_size = 2'd3; bus.i_req_signed = 1'b0;
        bus.i_wb_ack = 1'b0; bus.i_wb_stall = 1'b0;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("wait_cyc", 64'(bus.o_wb_cyc), 64'd1);
        chk("wait_stb", 64'(bus.o_wb_stb), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_cyc", 64'(bus.o_wb_cyc), 64'd0);
        chk("async_stb", 64'(bus.o_wb_stb), 64'd0);
        chk("async_ready", 64'(bus.o_req_ready), 64'd0);
        saw_rsp = 1'b0;
        bus.i_wb_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.o_rsp_valid) saw_rsp = 1'b1;
        end
        bus.i_wb_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (bus.o_rsp_valid) saw_rsp = 1'b1;
        chk("no_rsp_after_reset", 64'(saw_rsp), 64'd0);
        chk("ready_after_mid_reset", 64'(bus.o_req_ready), 64'd1);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            rv.we = 1'($urandom);
            rv.size = 2'($urandom);
            rv.sgn = 1'($urandom);
            rv.addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) rv.addr[2:0] = 3'd0;
            rv.wdata = {$urandom, $urandom};
            rv.rdat = {$urandom, $urandom};
            rv.stall_n = $urandom_range(0, 4);
            rv.ack_at = $urandom_range(0, 10);
            rv = model(rv);
            apply(rv, 100 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_master.md
# wb_master

Single-outstanding Wishbone (pipelined, stall/ack) bus initiator for the WivCPU load/store path. Accepts one sized load/store request at a time from the core, drives the 64-bit Wishbone bus toward memory-mapped responders such as the DDR3 bridge, and returns read data sized and extended per the request. A watchdog converts a missing acknowledge into an error response, so an unmapped address never hangs the pipeline.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles `o_wb_cyc` may stay high without `i_wb_ack` before the transaction is aborted; legal range 1..65535.
- ALIGN_CHECK, 1: when 1, a request not naturally aligned to its size is rejected with an error and no bus cycle.

Ports:
- i_clk  in  1  sole clock; all logic on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  core request present.
- o_req_ready  out  1  block can accept a request (high only in IDLE).
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  64  byte address.
- i_req_wdata  in  64  store data, right-justified (byte at `addr` in bits [7:0]).
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- i_req_signed  in  1  loads: sign-extend when 1, zero-extend when 0.
- o_rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- o_rsp_rdata  out  64  load result; 0 for stores and errors.
- o_rsp_err  out  1  qualifies `o_rsp_valid`: timeout or misalignment.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone cycle, strobe, write enable.
- o_wb_adr  out  64  byte address (equal to `i_req_addr`).
- o_wb_dat  out  64  right-justified write data, bytes above the size forced to 0.
- o_wb_sel  out  8  lane enables = (1 << (1 << size)) − 1, i.e. 0x01/0x03/0x0F/0xFF.
- i_wb_dat  in  64  right-justified read data.
- i_wb_ack, i_wb_stall  in  1 each  responder acknowledge and stall.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `o_req_ready` = 1. `i_req_valid` captures the address, data, size, we and signed fields into registers.
  - If ALIGN_CHECK=1 and `addr & ((1 << size) − 1)` ≠ 0, go to RESP with err=1.
  - Otherwise go to REQ.
- REQ: `cyc` = `stb` = 1. The strobe is accepted on a cycle with `!i_wb_stall`. On acceptance, go to WAIT, or go directly to RESP if `i_wb_ack` is also high that cycle.
- WAIT: `cyc` = 1, `stb` = 0. `i_wb_ack` latches the result and goes to RESP.
- An `i_wb_ack` seen in REQ while stalled also completes the transaction; the responder is trusted.
- Watchdog: a 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES without ack, `cyc`/`stb` drop and the block goes to RESP with err=1.
- RESP: `o_rsp_valid` = 1 for exactly one cycle, then IDLE.
- Load data, by size: lane bits [8·2^size−1:0] of `i_wb_dat`, extended to 64 bits per the signed flag. Size 3 passes through unchanged.
- `i_wb_ack` / `i_wb_dat` in IDLE or RESP are ignored.

## Timing
- Reset (async assert): all outputs 0 (`o_req_ready` = 0 while reset is held), state IDLE, counter 0. On deassert, `o_req_ready` = 1 on the first clock edge.
- Reset mid-transaction: `cyc`/`stb` fall immediately and no response is issued.
- All outputs are registered except `o_req_ready`, which is decoded from the state.
- Latency, no stall, ack with the strobe: request accepted at edge 0, `cyc`/`stb` high in cycle 1, `o_rsp_valid` high in cycle 2. Next request accepted at edge 3.
- Each stall cycle and each ack-wait cycle adds one cycle of latency.
- Misaligned request: `o_rsp_valid` high in cycle 1; no bus activity.
- Timeout: `cyc` is high for exactly TIMEOUT_CYCLES cycles, then `o_rsp_valid` with err=1 follows in the next cycle.
- Bus address, data, sel and we are stable for the whole of `cyc`.

## Test plan
- Load double at 0x8000_0010 with responder ack in the same cycle, `i_wb_dat` = 0x1122_3344_5566_7788. Required: `o_wb_sel` = 0xFF; rsp in cycle 2 with rdata = 0x1122_3344_5566_7788 and err = 0.
- Signed byte load at 0x8000_0003 with `i_wb_dat[7:0]` = 0x80. Required: `sel` = 0x01, rdata = 0xFFFF_FFFF_FFFF_FF80. Repeat unsigned: rdata = 0x80.
- Half store at 0x8000_0006 with wdata = 0xDEAD_BEEF_CAFE_1234, stall held 3 cycles, ack 2 cycles after acceptance. Required: `o_wb_dat` = 0x1234, `sel` = 0x03, `stb` high 4 cycles, one rsp with err = 0.
- Word load at 0x8000_0002 with ALIGN_CHECK=1. Required: rsp in cycle 1 with err = 1 and rdata = 0; `cyc` never rises.
- TIMEOUT_CYCLES=8 and no ack ever. Required: `cyc` high exactly 8 cycles, then a single rsp with err = 1; a following request completes normally.
- Assert `i_reset_n` = 0 while in WAIT. Required: `cyc`/`stb` = 0 without waiting for a clock edge; no rsp; after release, `o_req_ready` = 1.
